// File: rtl/hd_pack_pkg.sv
// Shared constants for the hard-decision frame packer.
// Frame geometry, FIFO sizing and frame-tracking state encoding.
package hd_pack_pkg;

  localparam int HDDW            = 32;
  localparam int KB              = 14;
  localparam int UNLOADCOUNT     = 17;
  localparam int WORDS_PER_FRAME = KB * UNLOADCOUNT;
  localparam int FIFODEPTH       = 16;
  localparam int ADDRESSWIDTH    = 4;
  localparam int CNTW            = 8;
  localparam int ENTW            = HDDW + 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

endpackage

// File: rtl/hd_frame_packer_if.sv
// Host-side valid/ready stream of the frame packer.
// master drives the word, slave drives the accept.
interface hd_frame_packer_if #(
  parameter int W = 32
);

  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/hd_sync_fifo.sv
// Parametric first-word-fall-through FIFO, single clock.
// A pop on a full FIFO frees the slot for a same-cycle push.
module hd_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_L);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/hd_frame_packer.sv
// Tags decoder words with frame boundaries and buffers them for the host.
// Optional counters under HD_FRAME_PACKER_STATS_EN.
module hd_frame_packer #(
  parameter int HDDW            = hd_pack_pkg::HDDW,
  parameter int KB              = hd_pack_pkg::KB,
  parameter int UNLOADCOUNT     = hd_pack_pkg::UNLOADCOUNT,
  parameter int WORDS_PER_FRAME = KB * UNLOADCOUNT,
  parameter int FIFODEPTH       = hd_pack_pkg::FIFODEPTH,
  parameter int ADDRESSWIDTH    = hd_pack_pkg::ADDRESSWIDTH,
  parameter int CNTW            = hd_pack_pkg::CNTW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  datavalid,
  input  logic [HDDW-1:0]       HD_out,
  input  logic                  frame_start,
  hd_frame_packer_if.master     m,
  input  logic                  err_clear,
  output logic                  err_overflow,
  output logic                  err_short,
  output logic [ADDRESSWIDTH:0] fifo_level
`ifdef HD_FRAME_PACKER_STATS_EN
  ,
  output logic [15:0]           frames_done,
  output logic [15:0]           words_dropped
`endif
);

  import hd_pack_pkg::*;

  localparam logic [CNTW-1:0] LAST_IDX =
    CNTW'(WORDS_PER_FRAME - 1);

  logic [CNTW-1:0] wr_idx;
  logic [CNTW-1:0] idx_eff;
  logic            last_tag;
  logic            pop;
  logic            full;
  logic            empty;
  logic            drop;
  logic            short_ev;
  logic [0:0]      state;
  logic [HDDW:0]   head;

  // frame_start forces index 0 for a word arriving in the same cycle
  assign idx_eff  = frame_start ? '0 : wr_idx;
  assign last_tag = (idx_eff == LAST_IDX);
  assign pop      = m.m_valid & m.m_ready;
  assign drop     = datavalid & full & ~pop;
  assign short_ev = frame_start & (state == ACTIVE);

  assign m.m_valid = ~empty;
  assign m.m_data  = head[HDDW-1:0];
  assign m.m_last  = head[HDDW];

  hd_sync_fifo #(
    .W     (HDDW + 1),
    .DEPTH (FIFODEPTH),
    .AW    (ADDRESSWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (datavalid),
    .pop   (pop),
    .din   ({last_tag, HD_out}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Index advances on drops too, keeping alignment
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
    end else if (datavalid) begin
      wr_idx <= last_tag ? '0 : idx_eff + 1'b1;
    end else if (frame_start) begin
      wr_idx <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      priority case (1'b1)
        datavalid:   state <= last_tag ? IDLE : ACTIVE;
        frame_start: state <= IDLE;
        default:     state <= state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      err_overflow <= drop | (err_overflow & ~err_clear);
      err_short    <= short_ev | (err_short & ~err_clear);
    end
  end

`ifdef HD_FRAME_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || err_clear) begin
      frames_done   <= '0;
      words_dropped <= '0;
    end else begin
      if (pop && m.m_last) begin
        frames_done <= frames_done + 1'b1;
      end
      if (drop && words_dropped != 16'hFFFF) begin
        words_dropped <= words_dropped + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hd_frame_packer.sv
// Self-checking bench for hd_frame_packer: vector table,
// directed frame sequences and random traffic against a queue model.
module tb_hd_frame_packer;

  localparam int W     = 32;
  localparam int WPF   = 238;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        datavalid;
  logic [31:0] HD_out;
  logic        frame_start;
  logic        err_clear;
  logic        err_overflow;
  logic        err_short;
  logic [4:0]  fifo_level;
`ifdef HD_FRAME_PACKER_STATS_EN
  logic [15:0] frames_done;
  logic [15:0] words_dropped;
`endif

  hd_frame_packer_if #(.W(W)) bus ();

  always #5 clk = ~clk;

  hd_frame_packer dut (
    .clk          (clk),
    .rst          (rst),
    .datavalid    (datavalid),
    .HD_out       (HD_out),
    .frame_start  (frame_start),
    .m            (bus),
    .err_clear    (err_clear),
    .err_overflow (err_overflow),
    .err_short    (err_short),
    .fifo_level   (fifo_level)
`ifdef HD_FRAME_PACKER_STATS_EN
    ,
    .frames_done   (frames_done),
    .words_dropped (words_dropped)
`endif
  );

  // reference model state
  logic [32:0] q[$];
  int idx;
  bit ovf_m;
  bit short_m;
  int fd_m;
  int wd_m;

  int checks = 0;
  int fails  = 0;
  int lasts_seen;
  int last_val;
  int max_lvl;

  typedef struct {
    bit          dv;
    logic [31:0] d;
    bit          fs;
    bit          rdy;
    bit          clr;
    bit          ev;
    logic [31:0] ed;
    bit          el;
    int          elvl;
    bit          eovf;
    bit          esh;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("m_valid", 64'(bus.m_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_data", 64'(bus.m_data), 64'(q[0][31:0]));
      chk("m_last", 64'(bus.m_last), 64'(q[0][32]));
    end
    chk("fifo_level", 64'(fifo_level), 64'(q.size()));
    chk("err_overflow", 64'(err_overflow), 64'(ovf_m));
    chk("err_short", 64'(err_short), 64'(short_m));
`ifdef HD_FRAME_PACKER_STATS_EN
    chk("frames_done", 64'(frames_done), 64'(fd_m));
    chk("words_dropped", 64'(words_dropped), 64'(wd_m));
`endif
  endtask

  task automatic step(input bit r, input bit dv,
                      input logic [31:0] d, input bit fs,
                      input bit rdy, input bit clr);
    bit pop;
    bit full;
    bit sh;
    bit drp;
    bit plast;
    bit lt;
    int i;
    rst         = r;
    datavalid   = dv;
    HD_out      = d;
    frame_start = fs;
    bus.m_ready = rdy;
    err_clear   = clr;
    #1;
    if (!r && bus.m_valid && rdy && bus.m_last) begin
      lasts_seen++;
      last_val = bus.m_data;
    end
    @(posedge clk);
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    if (r) begin
      q.delete();
      idx     = 0;
      ovf_m   = 0;
      short_m = 0;
      fd_m    = 0;
      wd_m    = 0;
    end else begin
      sh    = fs && (idx != 0);
      drp   = 0;
      plast = 0;
      i     = fs ? 0 : idx;
      if (pop) begin
        plast = q[0][32];
        void'(q.pop_front());
      end
      if (dv) begin
        lt = (i == WPF - 1);
        if (!full || pop) q.push_back({lt, d});
        else drp = 1;
        idx = (i + 1) % WPF;
      end else begin
        idx = i;
      end
      ovf_m   = drp || (ovf_m && !clr);
      short_m = sh || (short_m && !clr);
      if (clr) begin
        fd_m = 0;
        wd_m = 0;
      end else begin
        if (pop && plast) fd_m = (fd_m + 1) % 65536;
        if (drp && wd_m < 65535) wd_m++;
      end
    end
    #1;
    check_all();
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic nominal(input int base);
    step(0, 1, 32'(base), 1, 1, 0);
    for (int k = 1; k < WPF; k++)
      step(0, 1, 32'(base + k), 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    tv[0] = '{1, 32'hA5A50001, 1, 0, 0, 1, 32'hA5A50001, 0, 1, 0, 0};
    tv[1] = '{1, 32'hA5A50002, 0, 0, 0, 1, 32'hA5A50001, 0, 2, 0, 0};
    tv[2] = '{0, 32'h0, 0, 1, 0, 1, 32'hA5A50002, 0, 1, 0, 0};
    tv[3] = '{1, 32'hA5A50003, 0, 1, 0, 1, 32'hA5A50003, 0, 1, 0, 0};
    tv[4] = '{0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0};
    tv[5] = '{0, 32'h0, 1, 1, 0, 0, 32'h0, 0, 0, 0, 1};
    tv[6] = '{0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 0, 0, 0};
    tv[7] = '{1, 32'hA5A50004, 1, 0, 0, 1, 32'hA5A50004, 0, 1, 0, 0};

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_valid", 64'(bus.m_valid), 0);
    chk("rst_data", 64'(bus.m_data), 0);
    chk("rst_last", 64'(bus.m_last), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_ovf", 64'(err_overflow), 0);
    chk("rst_short", 64'(err_short), 0);

    for (int v = 0; v < 8; v++) begin
      step(0, tv[v].dv, tv[v].d, tv[v].fs, tv[v].rdy, tv[v].clr);
      chk("tv_valid", 64'(bus.m_valid), 64'(tv[v].ev));
      if (tv[v].ev) begin
        chk("tv_data", 64'(bus.m_data), 64'(tv[v].ed));
        chk("tv_last", 64'(bus.m_last), 64'(tv[v].el));
      end
      chk("tv_level", 64'(fifo_level), 64'(tv[v].elvl));
      chk("tv_ovf", 64'(err_overflow), 64'(tv[v].eovf));
      chk("tv_short", 64'(err_short), 64'(tv[v].esh));
    end

    // nominal frame
    do_reset();
    max_lvl    = 0;
    lasts_seen = 0;
    last_val   = -1;
    nominal(0);
    chk("nom_lasts", 64'(lasts_seen), 1);
    chk("nom_last_val", 64'(last_val), 237);
    chk("nom_max_level", 64'(max_lvl <= 1), 1);
    chk("nom_ovf", 64'(err_overflow), 0);
    chk("nom_short", 64'(err_short), 0);

    // overflow, then alignment of the next m_last
    do_reset();
    lasts_seen = 0;
    step(0, 1, 0, 1, 0, 0);
    for (int k = 1; k < 17; k++) step(0, 1, 32'(k), 0, 0, 0);
    chk("ovf_level", 64'(fifo_level), 16);
    chk("ovf_err", 64'(err_overflow), 1);
    for (int k = 0; k < 16; k++) step(0, 0, 0, 0, 1, 0);
    chk("ovf_drained", 64'(fifo_level), 0);
    for (int k = 17; k < WPF; k++) step(0, 1, 32'(k), 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("ovf_lasts", 64'(lasts_seen), 1);
    chk("ovf_last_val", 64'(last_val), 237);
    step(0, 0, 0, 0, 1, 1);
    chk("ovf_clear", 64'(err_overflow), 0);

    // full with simultaneous push and pop
    do_reset();
    step(0, 1, 100, 1, 0, 0);
    for (int k = 1; k < 16; k++) step(0, 1, 32'(100 + k), 0, 0, 0);
    chk("full_level", 64'(fifo_level), 16);
    step(0, 1, 116, 0, 1, 0);
    chk("full_pp_level", 64'(fifo_level), 16);
    chk("full_pp_ovf", 64'(err_overflow), 0);
    chk("full_pp_head", 64'(bus.m_data), 101);
    for (int k = 0; k < 17; k++) step(0, 0, 0, 0, 1, 0);

    // short frame
    do_reset();
    step(0, 1, 0, 1, 1, 0);
    for (int k = 1; k < 100; k++) step(0, 1, 32'(k), 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("short_set", 64'(err_short), 1);
    lasts_seen = 0;
    for (int k = 0; k < WPF; k++) step(0, 1, 32'(1000 + k), 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("short_lasts", 64'(lasts_seen), 1);
    chk("short_last_val", 64'(last_val), 1237);
    step(0, 0, 0, 0, 1, 1);
    chk("short_clear", 64'(err_short), 0);

    // reset mid-frame
    do_reset();
    step(0, 1, 0, 1, 0, 0);
    for (int k = 1; k < 50; k++) step(0, 1, 32'(k), 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("mrst_valid", 64'(bus.m_valid), 0);
    chk("mrst_level", 64'(fifo_level), 0);
    chk("mrst_ovf", 64'(err_overflow), 0);
    chk("mrst_short", 64'(err_short), 0);
    lasts_seen = 0;
    nominal(5000);
    chk("mrst_lasts", 64'(lasts_seen), 1);
    chk("mrst_last_val", 64'(last_val), 5237);

`ifdef HD_FRAME_PACKER_STATS_EN
    do_reset();
    for (int f = 0; f < 3; f++) nominal(f * 1000);
    step(0, 1, 0, 1, 0, 0);
    for (int k = 1; k < 18; k++) step(0, 1, 32'(k), 0, 0, 0);
    chk("stats_frames", 64'(frames_done), 3);
    chk("stats_dropped", 64'(words_dropped), 2);
    step(0, 0, 0, 0, 0, 1);
    chk("stats_clr_frames", 64'(frames_done), 0);
    chk("stats_clr_dropped", 64'(words_dropped), 0);
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(999) == 0,
           $urandom_range(9) < 7,
           $urandom,
           $urandom_range(299) == 0,
           $urandom_range(9) < 6,
           $urandom_range(99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/hd_frame_packer.md
Name: hd_frame_packer

Overview:
- Consumes the hard-decision word stream from the decoder output interface (datavalid/HD_out, push-only, no backpressure).
- Buffers words in a small synchronous FIFO and tags frame boundaries.
- Presents a valid/ready stream (m_valid/m_data/m_last) to the host-side sink.
- Sits directly downstream of the output interface, in the out_clk domain, as its own single-clock block.

Parameters:
- HDDW, 32, width of one hard-decision word.
- KB, 14, message blocks per codeword location.
- UNLOADCOUNT, 17, locations unloaded per codeword.
- WORDS_PER_FRAME, 238, words per decoded frame (KB*UNLOADCOUNT).
- FIFODEPTH, 16, buffer entries.
- ADDRESSWIDTH, 4, log2(FIFODEPTH).
- CNTW, 8, width of the word-index counter (must hold WORDS_PER_FRAME-1).

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- datavalid  input  1  upstream word strobe.
- HD_out  input  HDDW  upstream hard-decision word.
- frame_start  input  1  one-cycle pulse at the start of each unload (same event as unload_start); resynchronises the word index.
- m_ready  input  1  downstream accept.
- m_valid  output  1  a word is available.
- m_data  output  HDDW  word at FIFO head.
- m_last  output  1  head word is the last of its frame.
- err_clear  input  1  clears sticky errors.
- err_overflow  output  1  sticky: a word was dropped because the FIFO was full.
- err_short  output  1  sticky: frame_start arrived mid-frame.
- fifo_level  output  ADDRESSWIDTH+1  current occupancy, 0..FIFODEPTH.

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied; wr_idx=0; m_valid=0, m_last=0, m_data=0, err_overflow=0, err_short=0, fifo_level=0. Reset mid-frame discards all buffered words and the partial frame.
- Write side:
  - push = datavalid.
  - Entry stored is {last_tag, HD_out}, with last_tag = (wr_idx == WORDS_PER_FRAME-1).
  - wr_idx increments on every push, whether accepted or dropped, so frame alignment survives a drop. It wraps to 0 after WORDS_PER_FRAME-1.
- frame_start:
  - Sets wr_idx to 0 for the cycle in which it is asserted.
  - If wr_idx != 0 when it arrives, err_short is set.
  - If frame_start and datavalid coincide, that word is index 0 and the counter becomes 1.
  - The previous short frame's last word is not re-tagged; the sink sees no m_last for it.
- Read side:
  - First-word-fall-through; m_valid = (level != 0).
  - m_data and m_last reflect the head entry.
  - pop = m_valid & m_ready.
- Latency: a word pushed at cycle N is visible on m_valid/m_data at N+1 when the FIFO was empty.
- Full and simultaneous events:
  - Accept = push & (!full | pop). With the FIFO full, a same-cycle pop frees a slot, so the push is accepted and level is unchanged.
  - A push with full & !pop is dropped and sets err_overflow.
  - Push and pop on an empty FIFO: the push is stored and the pop is impossible (m_valid=0).
- Pointers: ADDRESSWIDTH-bit and wrap modulo FIFODEPTH. level is a separate counter: +1 on accept only, -1 on pop only, unchanged when both occur.
- Error register: err_clear clears both sticky errors. If a set event and err_clear occur in the same cycle, the set wins.
- Control FSM (frame tracking, two states):
  - IDLE (wr_idx==0, no frame open) -> ACTIVE on an accepted or dropped push.
  - ACTIVE -> IDLE on the push with last_tag=1, or on frame_start (from ACTIVE this also raises err_short).
  - m_* outputs are independent of FSM state.

Optional Feature:
- Macro: HD_FRAME_PACKER_STATS_EN.
- When defined:
  - Adds output frames_done[15:0]: increments on pop with m_last=1, wrapping at 16'hFFFF.
  - Adds output words_dropped[15:0]: increments on each dropped push and saturates at 16'hFFFF.
  - Both counters reset to 0 on rst and are cleared by err_clear.
- When undefined: neither port nor its counter exists; all other behaviour is identical.

Decomposition:
- Package hd_pack_pkg holds:
  - the WORDS_PER_FRAME, KB, UNLOADCOUNT and HDDW defaults;
  - the two-state FSM encoding (IDLE=1'b0, ACTIVE=1'b1);
  - the entry width constant (HDDW+1).
- One sub-module: hd_sync_fifo, a parametric FWFT FIFO (width, depth) with push/pop/full/empty/level.
- hd_frame_packer owns tagging, the counters, the errors and the FSM.

Test Plan:
- Nominal frame: m_ready=1, frame_start, then 238 consecutive pushes of value i -> 238 outputs 0..237 in order, m_last=1 only on value 237, no errors, fifo_level never exceeds 1.
- Overflow: m_ready=0, 17 pushes -> fifo_level=16, 17th word dropped, err_overflow=1; then m_ready=1 -> words 0..15 drained. Next frame's m_last still lands on global word index 237.
- Full with simultaneous push/pop: fill to 16, then push with m_ready=1 -> accepted, level stays 16, no error, order preserved.
- Short frame: frame_start, 100 pushes, frame_start -> err_short=1; the next word carries index 0 and m_last appears 238 words later. err_clear -> err_short=0.
- Reset mid-frame: 50 words buffered with m_ready=0, assert rst -> m_valid=0, level=0, errors 0. The next frame_start plus 238 words behaves as the nominal frame.
- Stats (macro defined): 3 nominal frames plus 2 dropped words -> frames_done=3, words_dropped=2; err_clear -> both 0.
